// File: rtl/pll_ctrl_pkg.sv
// PLL reset sequencer shared types.
// State encoding and counter widths.
package pll_ctrl_pkg;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer.
// Async active-high reset, reset value 0.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // two back-to-back flops to settle metastability
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// iCE40 PLL and system reset sequencer on the 12 MHz reference clock.
// Optional lock-loss counter: define LOCK_LOSS_CNT_EN.
import pll_ctrl_pkg::*;

module pll_reset_seq #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 60000,
  parameter int STABLE_CYCLES  = 1200,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 16
) (
  input  logic              clk_12mhz,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              rearm,
  output logic              pll_resetb,
  output logic              sys_rst,
  output logic              pll_ok,
  output logic              fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX =
    RETRY_W'(MAX_RETRIES);

  logic               lk;
  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   timer_q;
  logic [CNT_W-1:0]   timer_d;
  logic [RETRY_W-1:0] retry_d;
  logic [RETRY_W-1:0] retry_inc;

  sync_2ff #(
    .W (1)
  ) u_lock_sync (
    .clk (clk_12mhz),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  assign retry_inc = retry_cnt + RETRY_W'(1);

  // next state, shared timer and retry bookkeeping
  always_comb begin
    state_d = state_q;
    retry_d = retry_cnt;
    timer_d = (timer_q == '1) ? timer_q
                              : timer_q + CNT_W'(1);
    unique case (state_q)
      PLL_RST: begin
        if (timer_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end
      end
      WAIT_LOCK: begin
        if (lk) begin
          state_d = STABLE;
          timer_d = '0;
        end else if (timer_q == TMO_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_MAX) ? FAULT
                                             : PLL_RST;
          timer_d = '0;
        end
      end
      STABLE: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == STB_LAST) begin
          state_d = RUN;
          retry_d = '0;
          timer_d = '0;
        end
      end
      RUN: begin
        if (!lk) begin
          state_d = PLL_RST;
          timer_d = '0;
        end
      end
      FAULT: begin
        if (rearm) begin
          state_d = PLL_RST;
          retry_d = '0;
          timer_d = '0;
        end
      end
      default: begin
        state_d = PLL_RST;
        timer_d = '0;
      end
    endcase
  end

  // state, timer and retry registers
  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      state_q   <= PLL_RST;
      timer_q   <= '0;
      retry_cnt <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_cnt <= retry_d;
    end
  end

  // outputs registered from the next state so they track it exactly
  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      pll_resetb <= 1'b0;
      sys_rst    <= 1'b1;
      pll_ok     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      pll_resetb <= (state_d == WAIT_LOCK) ||
                    (state_d == STABLE) ||
                    (state_d == RUN);
      sys_rst    <= (state_d != RUN);
      pll_ok     <= (state_d == RUN);
      fault      <= (state_d == FAULT);
    end
  end

`ifdef LOCK_LOSS_CNT_EN
  logic loss_inc;

  assign loss_inc = (state_q == RUN) && !lk;

  // saturating count of lock losses seen in RUN
  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      loss_cnt <= '0;
    end else if (loss_inc && (loss_cnt != '1)) begin
      loss_cnt <= loss_cnt + LOSS_W'(1);
    end
  end
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed self-checking bench for pll_reset_seq.
// Small timing parameters; loss expectations follow LOCK_LOSS_CNT_EN.
module tb_pll_reset_seq;

  logic       clk_12mhz;
  logic       rst;
  logic       pll_locked;
  logic       rearm;
  logic       pll_resetb;
  logic       sys_rst;
  logic       pll_ok;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int checks;
  int errors;

  pll_reset_seq #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (20),
    .STABLE_CYCLES  (8),
    .MAX_RETRIES    (3),
    .CNT_W          (16)
  ) dut (
    .clk_12mhz  (clk_12mhz),
    .rst        (rst),
    .pll_locked (pll_locked),
    .rearm      (rearm),
    .pll_resetb (pll_resetb),
    .sys_rst    (sys_rst),
    .pll_ok     (pll_ok),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  initial clk_12mhz = 1'b0;
  always #5 clk_12mhz = ~clk_12mhz;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_12mhz);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // {pll_resetb, sys_rst, pll_ok, fault}
  task automatic chk_o(input string tag,
                       input logic [3:0] exp);
    chk(tag, {28'd0, pll_resetb, sys_rst,
              pll_ok, fault}, {28'd0, exp});
  endtask

  function automatic int exp_loss(input int n);
`ifdef LOCK_LOSS_CNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  task automatic wait_ok(input string tag,
                         input logic want,
                         input int maxc);
    for (int n = 0; n < maxc && pll_ok !== want; n++)
      tick(1);
    chk(tag, {31'd0, pll_ok}, {31'd0, want});
  endtask

  // called #1 after an edge; releases before the next edge
  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    pll_locked = 1'b0;
    rearm      = 1'b0;

    // 1: reset values, then lock at cycle 10
    tick(2);
    chk_o("rst_out", 4'b0100);
    chk("rst_retry", 32'(retry_cnt), 0);
    chk("rst_loss", 32'(loss_cnt), 0);
    #2;
    rst = 1'b0;
    tick(3);
    chk_o("t1_c3", 4'b0100);
    tick(1);
    chk_o("t1_c4", 4'b1100);
    tick(5);
    pll_locked = 1'b1;
    tick(10);
    chk_o("t1_c19", 4'b1100);
    tick(1);
    chk_o("t1_c20", 4'b1010);
    chk("t1_retry", 32'(retry_cnt), 0);
    rearm = 1'b1;
    tick(1);
    rearm = 1'b0;
    chk_o("t1_rearm_ign", 4'b1010);

    // 2: three timeouts, fault, rearm
    pll_locked = 1'b0;
    do_reset();
    tick(23);
    chk_o("t2_c23", 4'b1100);
    chk("t2_r0", 32'(retry_cnt), 0);
    tick(1);
    chk_o("t2_c24", 4'b0100);
    chk("t2_r1", 32'(retry_cnt), 1);
    tick(4);
    chk_o("t2_c28", 4'b1100);
    tick(20);
    chk_o("t2_c48", 4'b0100);
    chk("t2_r2", 32'(retry_cnt), 2);
    tick(23);
    chk_o("t2_c71", 4'b1100);
    tick(1);
    chk_o("t2_c72", 4'b0101);
    chk("t2_r3", 32'(retry_cnt), 3);
    tick(10);
    pll_locked = 1'b1;
    tick(5);
    chk_o("t2_fault_hold", 4'b0101);
    rearm = 1'b1;
    tick(1);
    rearm = 1'b0;
    chk_o("t2_rearm", 4'b0100);
    chk("t2_rearm_r", 32'(retry_cnt), 0);
    tick(4);
    chk_o("t2_wait", 4'b1100);
    tick(8);
    chk_o("t2_pre_run", 4'b1100);
    tick(1);
    chk_o("t2_run", 4'b1010);
    chk("t2_run_r", 32'(retry_cnt), 0);

    // 3: one-cycle dropout at stable count 5
    pll_locked = 1'b1;
    do_reset();
    tick(8);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(2);
    chk_o("t3_c11", 4'b1100);
    tick(8);
    chk_o("t3_c19", 4'b1100);
    tick(1);
    chk_o("t3_c20", 4'b1010);
    chk("t3_retry", 32'(retry_cnt), 0);

    // 4: lock loss in RUN, relock
    tick(2);
    pll_locked = 1'b0;
    tick(2);
    chk_o("t4_c24", 4'b1010);
    tick(1);
    chk_o("t4_c25", 4'b0100);
    chk("t4_loss", 32'(loss_cnt), exp_loss(1));
    pll_locked = 1'b1;
    tick(12);
    chk_o("t4_c37", 4'b1100);
    tick(1);
    chk_o("t4_c38", 4'b1010);
    chk("t4_loss2", 32'(loss_cnt), exp_loss(1));
    chk("t4_retry", 32'(retry_cnt), 0);

    // 5a: rst in WAIT_LOCK of second attempt
    pll_locked = 1'b0;
    do_reset();
    tick(30);
    chk_o("t5_pre", 4'b1100);
    chk("t5_pre_r", 32'(retry_cnt), 1);
    rst = 1'b1;
    #1;
    chk_o("t5_async", 4'b0100);
    chk("t5_async_r", 32'(retry_cnt), 0);
    #1;
    rst = 1'b0;
    tick(3);
    chk_o("t5_c3", 4'b0100);
    tick(1);
    chk_o("t5_c4", 4'b1100);

    // 5b: rst in RUN after one loss
    pll_locked = 1'b1;
    do_reset();
    tick(13);
    chk_o("t5_run", 4'b1010);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    wait_ok("t5_drop", 1'b0, 10);
    wait_ok("t5_relock", 1'b1, 40);
    chk("t5_loss", 32'(loss_cnt), exp_loss(1));
    rst = 1'b1;
    #1;
    chk_o("t5_run_async", 4'b0100);
    chk("t5_run_loss", 32'(loss_cnt), 0);
    #1;
    rst = 1'b0;
    tick(12);
    chk_o("t5_re_c12", 4'b1100);
    tick(1);
    chk_o("t5_re_c13", 4'b1010);

    // 6: 300 lock losses, counter saturates
    for (int i = 1; i <= 300; i++) begin
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      wait_ok("t6_drop", 1'b0, 10);
      wait_ok("t6_relock", 1'b1, 40);
      if (i == 1 || i == 254 || i == 255 ||
          i == 256 || i == 300)
        chk($sformatf("t6_loss_%0d", i),
            32'(loss_cnt), exp_loss(i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
